// File: rtl/cnt1_arbiter.sv
// Vector-granular round-robin arbiter in front of a shared cnt1 pipeline, with a tag FIFO
// that tracks which requester owns each in-flight vector. Optional macro: CNT1_ARB_BACK2BACK_EN.
module cnt1_arbiter #(
    parameter int REQ_NO         = 2,
    parameter int BUS_WIDTH      = 128,
    parameter int SUB_VECTOR_NO  = 8,
    parameter int TAG_FIFO_DEPTH = 16,
    parameter int TAG_WIDTH      = (REQ_NO > 1) ? $clog2(REQ_NO) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [REQ_NO*BUS_WIDTH-1:0] req_Vector,
    input  logic [REQ_NO-1:0]           req_Valid,
    output logic [REQ_NO-1:0]           req_Ready,
    output logic [BUS_WIDTH-1:0]        cnt_Vector,
    output logic                        cnt_Valid,
    input  logic                        cnt_Ready,
    input  logic                        res_Done,
    output logic [TAG_WIDTH-1:0]        res_Tag,
    output logic                        res_TagValid,
    output logic [TAG_WIDTH-1:0]        grant,
    output logic                        grant_Active,
    output logic                        err_Underflow
);
    // state | meaning
    // IDLE  | no vector owns cnt1; arbitrate when a tag slot is free
    // BURST | grant owns cnt1 until SUB_VECTOR_NO beats are accepted
    typedef enum logic {IDLE, BURST} state_t;

    localparam int WC_W  = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam int PTR_W = (TAG_FIFO_DEPTH > 1) ? $clog2(TAG_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(TAG_FIFO_DEPTH + 1);

    state_t               state;
    logic [TAG_WIDTH-1:0] last;
    logic [WC_W-1:0]      wc;
    logic [TAG_WIDTH-1:0] mem [TAG_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;

    logic                 rr_found;
    logic [TAG_WIDTH-1:0] rr_winner;
    logic                 accept;
    logic                 last_beat;
    logic                 do_grant;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        int idx;
        idx       = 0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= REQ_NO; k++) begin
            idx = (int'(last) + k) % REQ_NO;
            if (!rr_found && req_Valid[idx]) begin
                rr_found  = 1'b1;
                rr_winner = TAG_WIDTH'(idx);
            end
        end
    end

    assign grant_Active = (state == BURST);
    assign accept       = grant_Active & cnt_Valid & cnt_Ready;
    assign last_beat    = accept && (wc == WC_W'(SUB_VECTOR_NO - 1));
    assign do_pop       = res_Done && (occ != '0);

    // Occupancy before any same-cycle pop gates a new grant.
`ifdef CNT1_ARB_BACK2BACK_EN
    assign do_grant = (!grant_Active || last_beat) && rr_found && (occ < OCC_W'(TAG_FIFO_DEPTH));
`else
    assign do_grant = !grant_Active && rr_found && (occ < OCC_W'(TAG_FIFO_DEPTH));
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            grant         <= '0;
            last          <= TAG_WIDTH'(REQ_NO - 1);
            wc            <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            err_Underflow <= 1'b0;
            for (int i = 0; i < TAG_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        state <= BURST;
                        grant <= rr_winner;
                        last  <= rr_winner;
                        wc    <= '0;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        if (do_grant) begin
                            grant <= rr_winner;
                            last  <= rr_winner;
                            wc    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        wc <= wc + WC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_grant) begin
                mem[wr_ptr] <= rr_winner;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);

            case ({do_grant, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (res_Done && (occ == '0)) err_Underflow <= 1'b1;
        end
    end

    assign res_Tag      = mem[rd_ptr];
    assign res_TagValid = (occ != '0);

    always_comb begin
        cnt_Vector = '0;
        cnt_Valid  = 1'b0;
        req_Ready  = '0;
        if (grant_Active) begin
            cnt_Vector       = req_Vector[int'(grant)*BUS_WIDTH +: BUS_WIDTH];
            cnt_Valid        = req_Valid[grant];
            req_Ready[grant] = cnt_Ready;
        end
    end
endmodule
